// File: rtl/encoder_16to4_sticky_pkg.sv
// Shared definitions for the sticky 16-to-4 priority encoder.
// Holds the line count, the index width and the offer FSM state enumeration.
package encoder_16to4_sticky_pkg;

    localparam int N_LINES = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/encoder_16to4_sticky_prio_enc.sv
// prio_enc_16to4: combinational priority encoder, the inverse of the 4-to-16 decoder.
// Ports:
//   vec       - input vector to encode
//   low_first - 1: lowest set index wins, 0: highest set index wins
//   idx       - encoded index (4'h0 when vec is zero)
//   any       - at least one bit of vec is set
module prio_enc_16to4
    import encoder_16to4_sticky_pkg::*;
(
    input  logic [N_LINES-1:0] vec,
    input  logic               low_first,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan order decides priority: the last set bit visited wins.
    always_comb begin
        idx = {IDX_W{1'b0}};
        any = |vec;
        if (low_first) begin
            for (int i = N_LINES - 1; i >= 0; i--) begin
                idx = vec[i] ? i[IDX_W-1:0] : idx;
            end
        end else begin
            for (int i = 0; i < N_LINES; i++) begin
                idx = vec[i] ? i[IDX_W-1:0] : idx;
            end
        end
    end

endmodule

// File: rtl/encoder_16to4_sticky.sv
// encoder_16to4_sticky: collects request pulses into a sticky pending register
// and offers one pending index at a time on a valid/ready handshake.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   req         - request pulses, bit i marks line i pending
//   clr         - synchronous flush of pending bits and any offer
//   out_idx     - offered line index (registered)
//   out_valid   - offer present (registered)
//   out_ready   - consumer accepts the offer when high with out_valid
//   pending     - sticky pending register (debug)
module encoder_16to4_sticky
    import encoder_16to4_sticky_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LINES-1:0] req,
    input  logic               clr,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_LINES-1:0] pending
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [N_LINES-1:0] pending_r;
    logic [N_LINES-1:0] pending_nxt_s;
    logic [N_LINES-1:0] held_s;
    logic [N_LINES-1:0] accept_mask_s;
    logic               accept_s;
    logic               out_valid_r;
    logic               out_valid_nxt_s;
    logic [IDX_W-1:0]   out_idx_r;
    logic [IDX_W-1:0]   out_idx_nxt_s;
    logic [N_LINES-1:0] enc_vec_s;
    logic [IDX_W-1:0]   enc_idx_s;
    logic               enc_any_s;

    assign accept_s = out_valid_r & out_ready;

    // Pending update: accepted bit clears, new requests set (set wins), clr flushes.
    always_comb begin
        accept_mask_s = {N_LINES{1'b0}};
        if (accept_s) begin
            accept_mask_s = 16'h0001 << out_idx_r;
        end else begin
            accept_mask_s = {N_LINES{1'b0}};
        end
        held_s = (pending_r & ~accept_mask_s) | req;
        if (clr) begin
            pending_nxt_s = {N_LINES{1'b0}};
        end else begin
            pending_nxt_s = held_s;
        end
    end

    // Idle offers from the registered pending; an accepting offer chains
    // straight into the post-accept pending so accepts can run back to back.
    always_comb begin
        enc_vec_s = pending_r;
        if (state_r == ST_OFFER) begin
            enc_vec_s = held_s;
        end else begin
            enc_vec_s = pending_r;
        end
    end

    prio_enc_16to4 u_prio_enc (
        .vec       (enc_vec_s),
        .low_first (LOW_FIRST),
        .idx       (enc_idx_s),
        .any       (enc_any_s)
    );

    // Offer FSM next-state and next-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        out_valid_nxt_s = out_valid_r;
        out_idx_nxt_s   = out_idx_r;
        if (clr) begin
            state_nxt_s     = ST_IDLE;
            out_valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enc_any_s) begin
                        state_nxt_s     = ST_OFFER;
                        out_valid_nxt_s = 1'b1;
                        out_idx_nxt_s   = enc_idx_s;
                    end else begin
                        state_nxt_s     = ST_IDLE;
                        out_valid_nxt_s = 1'b0;
                    end
                end
                ST_OFFER: begin
                    // The offered index is frozen until it is accepted.
                    if (accept_s && enc_any_s) begin
                        state_nxt_s     = ST_OFFER;
                        out_valid_nxt_s = 1'b1;
                        out_idx_nxt_s   = enc_idx_s;
                    end else if (accept_s) begin
                        state_nxt_s     = ST_IDLE;
                        out_valid_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s     = ST_OFFER;
                        out_valid_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    out_valid_nxt_s = 1'b0;
                    out_idx_nxt_s   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pending_r   <= {N_LINES{1'b0}};
            out_valid_r <= 1'b0;
            out_idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_idx_r   <= out_idx_nxt_s;
        end
    end

    assign out_idx   = out_idx_r;
    assign out_valid = out_valid_r;
    assign pending   = pending_r;

endmodule

// File: tb/tb_encoder_16to4_sticky.sv
// Scoreboard bench: two instances (highest-first and lowest-first) share the
// stimulus; a reference model predicts each accepted index into a queue that
// a negedge monitor pops whenever the DUT handshakes.
module tb_encoder_16to4_sticky;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] req = 16'h0000;
    logic [3:0]  oidx0, oidx1;
    logic        ov0, ov1;
    logic [15:0] pend0, pend1;

    always #5 clk = ~clk;

    encoder_16to4_sticky #(.LOW_FIRST(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
        .out_idx(oidx0), .out_valid(ov0), .out_ready(out_ready), .pending(pend0)
    );

    encoder_16to4_sticky #(.LOW_FIRST(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
        .out_idx(oidx1), .out_valid(ov1), .out_ready(out_ready), .pending(pend1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_pend [2];
    int          m_off [2];
    bit          exp_v [2];
    logic [15:0] exp_pend [2];
    bit          armed = 1'b0;
    int          sb0[$], sb1[$], log0[$], log1[$];

    // Winning index of a vector under the given priority, -1 when empty.
    function automatic int pick(input logic [15:0] v, input bit low);
        int r;
        r = -1;
        for (int i = 0; i < 16; i++) begin
            if (v[i] && (!low || r < 0)) r = i;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: pending set of lines plus the currently offered line (-1 = none).
    task automatic model_update(input int k, input logic [15:0] r, input bit c, input bit rdy);
        logic [15:0] old;
        logic [15:0] p;
        bit          acc;
        old = m_pend[k];
        acc = (m_off[k] >= 0) && rdy;
        if (c) begin
            m_pend[k] = 16'h0000;
            m_off[k]  = -1;
        end else begin
            p = old;
            if (acc) p[m_off[k]] = 1'b0;
            p = p | r;
            m_pend[k] = p;
            if (m_off[k] < 0) m_off[k] = pick(old, k == 1);
            else if (acc) m_off[k] = pick(p, k == 1);
        end
    endtask

    task automatic step(input logic [15:0] r, input bit c, input bit rdy);
        @(posedge clk);
        #1;
        req = r;
        clr = c;
        out_ready = rdy;
        armed = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_v[k]    = (m_off[k] >= 0);
            exp_pend[k] = m_pend[k];
            if (m_off[k] >= 0 && rdy && !c) begin
                if (k == 0) sb0.push_back(m_off[k]);
                else        sb1.push_back(m_off[k]);
            end
            model_update(k, r, c, rdy);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        armed = 1'b0;
        req = 16'hFFFF;
        clr = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid_hi", ov0, 0);
        check("rst_idx_hi", oidx0, 0);
        check("rst_pending_hi", pend0, 0);
        check("rst_valid_lo", ov1, 0);
        check("rst_idx_lo", oidx1, 0);
        check("rst_pending_lo", pend1, 0);
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 16'h0000;
            m_off[k]  = -1;
        end
        sb0.delete();
        sb1.delete();
        repeat (2) @(posedge clk);
        #1;
        req = 16'h0000;
        rst_n = 1'b1;
    endtask

    task automatic expect_order(input string name, input int k, input int e[$]);
        int a[$];
        if (k == 0) a = log0;
        else        a = log1;
        check({name, "_count"}, a.size(), e.size());
        for (int i = 0; i < e.size() && i < a.size(); i++) begin
            check(name, a[i], e[i]);
        end
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
    endtask

    // Monitor: per-cycle valid/pending comparison and scoreboard pop on handshake.
    always @(negedge clk) begin : monitor
        int e;
        if (armed && rst_n) begin
            check("valid_hi", ov0, exp_v[0]);
            check("pending_hi", pend0, exp_pend[0]);
            check("valid_lo", ov1, exp_v[1]);
            check("pending_lo", pend1, exp_pend[1]);
            if (ov0 && out_ready && !clr) begin
                if (sb0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_hi: got idx %0d expected no accept", oidx0);
                end else begin
                    e = sb0.pop_front();
                    check("accept_idx_hi", oidx0, e);
                    log0.push_back(int'(oidx0));
                end
            end
            if (ov1 && out_ready && !clr) begin
                if (sb1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_lo: got idx %0d expected no accept", oidx1);
                end else begin
                    e = sb1.pop_front();
                    check("accept_idx_lo", oidx1, e);
                    log1.push_back(int'(oidx1));
                end
            end
        end
    end

    initial begin
        int          e[$];
        logic [15:0] r;
        bit          rdy;
        bit          c;

        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 16'h0000;
            m_off[k]  = -1;
        end
        do_reset();

        // Single pulse on line 5, ready held high.
        clear_logs();
        step(16'h0020, 1'b0, 1'b1);
        repeat (4) step(16'h0000, 1'b0, 1'b1);
        e = {5};
        expect_order("pulse5_hi", 0, e);
        expect_order("pulse5_lo", 1, e);

        // Lines 15 and 0 together, 5-cycle stall, then drain.
        clear_logs();
        step(16'h8001, 1'b0, 1'b0);
        repeat (6) step(16'h0000, 1'b0, 1'b0);
        repeat (3) step(16'h0000, 1'b0, 1'b1);
        e = {15, 0};
        expect_order("pair_hi", 0, e);
        e = {0, 15};
        expect_order("pair_lo", 1, e);

        // Offer 3 stalled, line 10 arrives; 3 must be delivered first.
        clear_logs();
        step(16'h0008, 1'b0, 1'b0);
        repeat (3) step(16'h0000, 1'b0, 1'b0);
        step(16'h0400, 1'b0, 1'b0);
        repeat (2) step(16'h0000, 1'b0, 1'b0);
        repeat (3) step(16'h0000, 1'b0, 1'b1);
        e = {3, 10};
        expect_order("stable_hi", 0, e);
        expect_order("stable_lo", 1, e);

        // Accept 7 while req[7] is high: 7 is offered again.
        clear_logs();
        step(16'h0080, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0080, 1'b0, 1'b1);
        repeat (2) step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0);
        e = {7, 7};
        expect_order("setwins_hi", 0, e);
        expect_order("setwins_lo", 1, e);

        // All 16 lines pending, drained one per cycle.
        clear_logs();
        step(16'hFFFF, 1'b0, 1'b1);
        repeat (19) step(16'h0000, 1'b0, 1'b1);
        e = {};
        for (int i = 15; i >= 0; i--) e.push_back(i);
        expect_order("drain_hi", 0, e);
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(i);
        expect_order("drain_lo", 1, e);

        // clr during an offer with a request and an accept in the same cycle.
        clear_logs();
        step(16'h0010, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0002, 1'b1, 1'b1);
        repeat (3) step(16'h0000, 1'b0, 1'b1);
        e = {};
        expect_order("clr_hi", 0, e);
        expect_order("clr_lo", 1, e);

        // Reset in the middle of an offer; pre-reset requests must not survive.
        clear_logs();
        step(16'h0100, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b0);
        do_reset();
        repeat (4) step(16'h0000, 1'b0, 1'b1);
        e = {};
        expect_order("rst_hi", 0, e);
        expect_order("rst_lo", 1, e);

        // Randomized traffic with occasional clr and reset.
        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 199) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0:       r = 16'($urandom);
                    1:       r = 16'h0001 << $urandom_range(0, 15);
                    default: r = 16'h0000;
                endcase
                rdy = ($urandom_range(0, 2) != 0);
                c   = ($urandom_range(0, 49) == 0);
                step(r, c, rdy);
            end
        end
        repeat (20) step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("scoreboard_empty_hi", sb0.size(), 0);
        check("scoreboard_empty_lo", sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_16to4_sticky.md
ENCODER_16TO4_STICKY -- requirements
Module: encoder_16to4_sticky

Interface
REQ-001 Parameter LOW_FIRST, default 0: 0 = highest index wins, 1 = lowest index wins.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  16  request bits; bit i high for one or more cycles marks line i pending.
REQ-005 clr  input  1  synchronous flush of all pending bits and any offer.
REQ-006 out_idx  output  4  binary index of the offered line.
REQ-007 out_valid  output  1  out_idx holds a valid offer.
REQ-008 out_ready  input  1  consumer accepts the offer when high with out_valid.
REQ-009 pending  output  16  current sticky pending register, for debug.

Function
REQ-010 Pending bit i SHALL set on any cycle where req[i]=1 and stay set until its index is accepted or clr is applied.
REQ-011 Acceptance SHALL be a cycle with out_valid=1 and out_ready=1; the accepted index's pending bit clears on that edge.
REQ-012 If req[i]=1 on the accept cycle of index i, bit i SHALL remain set: set wins over clear.
REQ-013 FSM states are IDLE and OFFER.
REQ-014 IDLE: out_valid=0; on any edge where the registered pending is non-zero, go to OFFER with out_idx = priority-encoded index of that registered pending.
REQ-015 Latency from req[i] rising, with the block idle, to out_valid=1 SHALL be 2 cycles: edge 1 sets pending, edge 2 loads the offer.
REQ-016 OFFER: out_valid=1; out_idx SHALL stay stable until accepted, even if a higher-priority bit becomes pending.
REQ-017 On accept, if pending after the clear is non-zero, stay in OFFER with out_idx = its priority-encoded index on the next cycle; otherwise go to IDLE. Back-to-back accepts give one index per cycle.
REQ-018 Priority encode SHALL be the exact inverse of the team's 4-to-16 decoder: a one-hot pending bit i gives out_idx=i.
REQ-019 With several bits pending, LOW_FIRST=0 SHALL select the highest set index and LOW_FIRST=1 the lowest.
REQ-020 out_ready while out_valid=0 SHALL have no effect.
REQ-021 clr=1 SHALL zero pending and force IDLE on that edge, overriding req and any accept in the same cycle.
REQ-022 All 16 bits pending: 16 consecutive accepts with out_ready held high SHALL drain them in strict priority order, then go to IDLE.

Reset
REQ-023 rst_n low SHALL immediately force pending=16'h0000, out_valid=0, out_idx=4'h0 and state IDLE, including in the middle of an offer.
REQ-024 After rst_n deasserts, the first edge SHALL act only on req sampled on that edge; no pre-reset request survives.

Structure
REQ-025 A shared package SHALL hold N_LINES=16, IDX_W=4 and the IDLE/OFFER state enumeration.
REQ-026 The priority encode SHALL be one combinational sub-module, prio_enc_16to4, with ports vec[15:0], low_first, idx[3:0] and any.
REQ-027 All outputs SHALL be driven from registers; out_idx SHALL be the registered output of prio_enc_16to4.

Verification
REQ-028 Reset, then req=16'h0020 pulsed 1 cycle, out_ready=1 -> out_valid high 2 cycles later with out_idx=5 for 1 cycle, then pending=0 and IDLE.
REQ-029 req=16'h8001 in one cycle, out_ready=0 for 5 cycles, then 1 -> out_idx=15 held stable for all 5 stall cycles, then 15 and 0 accepted on consecutive cycles; repeat with LOW_FIRST=1 -> order 0, 15.
REQ-030 Offer idx=3 stalled, then req=16'h0400 arrives -> out_idx stays 3 until accepted, then 10 next cycle.
REQ-031 Accept idx=7 while req[7]=1 in the same cycle -> pending[7] stays set, and 7 is offered again next cycle.
REQ-032 req=16'hFFFF for 1 cycle, out_ready=1 -> indices 15 down to 0 on 16 consecutive cycles, then out_valid=0.
REQ-033 clr together with req=16'h0002 and an accept during an offer, and separately rst_n low mid-offer -> pending=0, out_valid=0 next edge (clr) or immediately (reset), with no index emitted.
